// File: rtl/full_adder_core.sv
// Registered ripple-carry adder: WIDTH full-adder cells chained through a carry vector,
// with the sum, carry-out and signed overflow captured on each accepted operand set.
module full_adder_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Ca,
    output logic             Ovf,
    output logic             out_valid
);

    // c[i] is the carry into cell i; c[WIDTH] is the carry out of the MSB cell.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign s[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end

    // Result registers load only on accepted operands, so inputs are don't-care
    // (even X/Z) while in_valid is low.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            Sum       <= '0;
            Ca        <= 1'b0;
            Ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum <= s;
                Ca  <= c[WIDTH];
                Ovf <= c[WIDTH] ^ c[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_full_adder_core.sv
// Self-checking bench for full_adder_core: table-driven vectors on WIDTH=1 and WIDTH=8
// instances, hand-written reset/hold sequences, and a random back-to-back run on WIDTH=8.
module tb_full_adder_core;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       ca;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    logic       v1, a1, b1, cin1;
    logic       sum1, ca1, ovf1, ov1;
    logic       v8, cin8;
    logic [7:0] a8, b8;
    logic [7:0] sum8;
    logic       ca8, ovf8, ov8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    full_adder_core #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1), .Cin(cin1),
        .Sum(sum1), .Ca(ca1), .Ovf(ovf1), .out_valid(ov1)
    );

    full_adder_core #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .A(a8), .B(b8), .Cin(cin8),
        .Sum(sum8), .Ca(ca8), .Ovf(ovf8), .out_valid(ov8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string name, input logic s, input logic c, input logic o, input logic v);
        check({name, " w1 sum"},   64'(sum1), 64'(s));
        check({name, " w1 ca"},    64'(ca1),  64'(c));
        check({name, " w1 ovf"},   64'(ovf1), 64'(o));
        check({name, " w1 valid"}, 64'(ov1),  64'(v));
    endtask

    task automatic check8(input string name, input logic [7:0] s, input logic c, input logic o, input logic v);
        check({name, " w8 sum"},   64'(sum8), 64'(s));
        check({name, " w8 ca"},    64'(ca8),  64'(c));
        check({name, " w8 ovf"},   64'(ovf8), 64'(o));
        check({name, " w8 valid"}, 64'(ov8),  64'(v));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t w1_tab[8];
        vec_t w8_tab[9];
        logic [8:0] full;
        logic       exp_ovf;

        // {a, b, cin, sum, ca, ovf}; WIDTH=1 overflow is Ca ^ Cin.
        w1_tab = '{
            '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0},
            '{8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1},
            '{8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0},
            '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0},
            '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0},
            '{8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0},
            '{8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1},
            '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0}
        };
        w8_tab = '{
            '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
            '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
            '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
            '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
            '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0},
            '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0},
            '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1},
            '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1},
            '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0}
        };

        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        tick();
        tick();
        check1("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check8("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // WIDTH=1 exhaustive, back to back.
        v1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a1 = w1_tab[i].a[0]; b1 = w1_tab[i].b[0]; cin1 = w1_tab[i].cin;
            tick();
            check1($sformatf("w1 tab[%0d]", i), w1_tab[i].sum[0], w1_tab[i].ca, w1_tab[i].ovf, 1'b1);
        end

        // Reset wins over in_valid, then first valid result one cycle after release.
        rst = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        tick();
        check1("rst over valid", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check1("after rst", 1'b1, 1'b1, 1'b0, 1'b1);

        // Hold: outputs frozen while in_valid is low and inputs wander (including X).
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1;
        tick();
        check1("hold load", 1'b0, 1'b1, 1'b0, 1'b1);
        v1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a1 = i[0]; b1 = ~i[0]; cin1 = (i == 3) ? 1'bx : i[1];
            tick();
            check1($sformatf("hold[%0d]", i), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // WIDTH=8 directed table, back to back.
        v8 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a8 = w8_tab[i].a; b8 = w8_tab[i].b; cin8 = w8_tab[i].cin;
            tick();
            check8($sformatf("w8 tab[%0d]", i), w8_tab[i].sum, w8_tab[i].ca, w8_tab[i].ovf, 1'b1);
        end

        // WIDTH=8 hold with X inputs, then mid-stream reset discards the in-flight result.
        v8 = 1'b0; a8 = 8'hxx; b8 = 8'h5A; cin8 = 1'bx;
        tick();
        check8("w8 hold", 8'h47, 1'b0, 1'b0, 1'b0);
        v8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        rst = 1'b1;
        tick();
        check8("w8 mid rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check8("w8 post rst", 8'h80, 1'b0, 1'b1, 1'b1);

        // WIDTH=8 random, back to back; overflow from operand/result sign bits.
        for (int i = 0; i < 10000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            full    = 9'(a8) + 9'(b8) + 9'(cin8);
            exp_ovf = (a8[7] == b8[7]) && (full[7] != a8[7]);
            tick();
            check($sformatf("rand[%0d] {ca,sum}", i), 64'({ca8, sum8}), 64'(full));
            check($sformatf("rand[%0d] ovf", i), 64'(ovf8), 64'(exp_ovf));
            check($sformatf("rand[%0d] valid", i), 64'(ov8), 64'(1'b1));
        end

        v8 = 1'b0;
        tick();
        check("final valid drop", 64'(ov8), 64'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
